// File: rtl/stack_shift_ctrl.sv
// stack_shift_ctrl: bit-serial LIFO command sequencer driving a WIDTH*DEPTH shiftreg
// Optional STACK_SHIFT_CTRL_STICKY_ERR_EN: err holds from a rejected command until a CLEAR completes or rst.
module stack_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  input  logic [WIDTH-1:0]           sr_top,
  output logic                       sr_d,
  output logic                       sr_en,
  output logic                       sr_dir,
  output logic                       sr_rst,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       done,
  output logic                       err
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [1:0] OP_PUSH = 2'd0, OP_POP = 2'd1, OP_DUP = 2'd2, OP_CLR = 2'd3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op, op_n;
  logic [WIDTH-1:0] word, word_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] depth_n;
  logic rej, rej_n, accept, illegal;
  assign accept  = cmd_valid & (state == IDLE);
  assign full    = depth == DW'(DEPTH);
  assign empty   = depth == '0;
  assign illegal = ((cmd_op == OP_PUSH || cmd_op == OP_DUP) && full) ||
                   ((cmd_op == OP_POP || cmd_op == OP_DUP) && empty);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= OP_PUSH;
      word  <= '0;
      cnt   <= '0;
      depth <= '0;
      rej   <= 1'b0;
    end else begin
      state <= state_n;
      op    <= op_n;
      word  <= word_n;
      cnt   <= cnt_n;
      depth <= depth_n;
      rej   <= rej_n;
    end
  end
  always_comb begin
    state_n = state;
    op_n    = op;
    word_n  = word;
    cnt_n   = cnt;
    depth_n = depth;
    rej_n   = rej;
    unique case (state)
      IDLE: if (accept) begin
        op_n    = cmd_op;
        word_n  = cmd_op == OP_DUP ? sr_top : cmd_data;
        rej_n   = illegal;
        cnt_n   = '0;
        state_n = (cmd_op == OP_CLR || illegal) ? DONE : SHIFT;
        depth_n = cmd_op == OP_CLR ? '0 : depth;
      end
      SHIFT: begin
        // word shifts left so its MSB is always the next serial bit
        word_n = word << 1;
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(WIDTH-1)) begin
          cnt_n   = '0;
          state_n = DONE;
          depth_n = op == OP_POP ? depth - DW'(1) : depth + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        rej_n   = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  assign cmd_ready = state == IDLE;
  assign sr_en     = state == SHIFT;
  assign sr_dir    = sr_en & (op == OP_POP);
  assign sr_d      = sr_en & (op != OP_POP) & word[WIDTH-1];
  assign done      = state == DONE;
  assign sr_rst    = rst | (done & (op == OP_CLR));
`ifdef STACK_SHIFT_CTRL_STICKY_ERR_EN
  logic err_q;
  always_ff @(posedge clk)
    err_q <= rst ? 1'b0 : (accept & illegal) ? 1'b1 : (done & (op == OP_CLR)) ? 1'b0 : err_q;
  assign err = err_q;
`else
  assign err = done & rej;
`endif
endmodule

// File: tb/tb_stack_shift_ctrl.sv
// tb_stack_shift_ctrl: directed table, reset-abort sequence and random commands against a queue-based stack model
module tb_stack_shift_ctrl;
  localparam int W = 4, D = 4;
`ifdef STACK_SHIFT_CTRL_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [W-1:0] cmd_data = '0, sr_top;
  logic cmd_ready, sr_d, sr_en, sr_dir, sr_rst, empty, full, done, err;
  logic [2:0] depth;
  logic [W*D-1:0] q = '0;
  int checks = 0, errors = 0;
  logic [W-1:0] stk[$];
  bit sticky_m = 1'b0;
  int last_lat;
  typedef struct { logic [1:0] op; logic [W-1:0] data; bit rej; int dep; logic [W-1:0] top; } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  stack_shift_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .sr_top(sr_top), .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir),
    .sr_rst(sr_rst), .depth(depth), .empty(empty), .full(full), .done(done), .err(err)
  );

  // attached shiftreg
  always_ff @(posedge clk)
    q <= sr_rst ? '0 : sr_en ? (sr_dir ? {1'b0, q[W*D-1:1]} : {q[W*D-2:0], sr_d}) : q;
  assign sr_top = q[W-1:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mtop();
    return stk.size() > 0 ? stk[$] : '0;
  endfunction

  // issue one command from an IDLE negedge; returns at the following IDLE negedge
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data);
    int sz, lat, en_n, dir_n;
    bit ill, shf, got, d_rst, d_err, exp_err;
    logic [W-1:0] wexp, bits;
    logic [2:0] d_depth;
    sz = stk.size();
    ill = (op == 0 && sz == D) || (op == 1 && sz == 0) || (op == 2 && (sz == 0 || sz == D));
    shf = !ill && op != 3;
    wexp = op == 2 ? mtop() : data;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = W'($urandom);
    lat = 0; en_n = 0; dir_n = 0; bits = '0; got = 0; d_rst = 0; d_err = 0; d_depth = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sr_en) begin
        en_n++;
        bits = {bits[W-2:0], sr_d};
        dir_n += int'(sr_dir);
      end
      if (done) begin
        got = 1; d_rst = sr_rst; d_err = err; d_depth = depth;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    last_lat = lat;
    exp_err = ill | (STICKY & sticky_m);
    if (ill) sticky_m = 1'b1;
    if (!ill) case (op)
      2'd0: stk.push_back(data);
      2'd1: void'(stk.pop_back());
      2'd2: stk.push_back(wexp);
      default: begin stk.delete(); sticky_m = 1'b0; end
    endcase
    chk("done_latency", lat, shf ? W + 1 : 1);
    chk("en_cycles", en_n, shf ? W : 0);
    chk("dir_ones", dir_n, (shf && op == 1) ? W : 0);
    if (shf && op != 1) chk("serial_word", bits, wexp);
    chk("clear_sr_rst", d_rst, op == 3);
    chk("err_at_done", d_err, exp_err);
    chk("depth_at_done", d_depth, stk.size());
    @(negedge clk);
    chk("top", sr_top, mtop());
    chk("empty", empty, stk.size() == 0);
    chk("full", full, stk.size() == D);
    chk("ready_after", cmd_ready, 1);
    chk("err_idle", err, STICKY & sticky_m);
  endtask

  initial begin
    int r, dn;
    logic [1:0] op;
    tbl[0]  = '{0, 4'h5, 0, 1, 4'h5};
    tbl[1]  = '{2, 4'h0, 0, 2, 4'h5};
    tbl[2]  = '{1, 4'h0, 0, 1, 4'h5};
    tbl[3]  = '{0, 4'hA, 0, 2, 4'hA};
    tbl[4]  = '{0, 4'h3, 0, 3, 4'h3};
    tbl[5]  = '{1, 4'h0, 0, 2, 4'hA};
    tbl[6]  = '{0, 4'h1, 0, 3, 4'h1};
    tbl[7]  = '{0, 4'h2, 0, 4, 4'h2};
    tbl[8]  = '{0, 4'hF, 1, 4, 4'h2};
    tbl[9]  = '{2, 4'h0, 1, 4, 4'h2};
    tbl[10] = '{3, 4'h0, 0, 0, 4'h0};
    tbl[11] = '{1, 4'h0, 1, 0, 4'h0};
    tbl[12] = '{2, 4'h0, 1, 0, 4'h0};
    repeat (3) @(negedge clk);
    chk("rst_sr_rst", sr_rst, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_en", sr_en, 0);
    chk("rst_dir", sr_dir, 0);
    chk("rst_d", sr_d, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_depth", depth, 0);
    chk("rst_sr_rst_off", sr_rst, 0);
    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].data);
      chk("tbl_rej", last_lat == 1 && tbl[i].op != 3, tbl[i].rej);
      chk("tbl_depth", depth, tbl[i].dep);
      chk("tbl_top", sr_top, tbl[i].top);
    end
    // reset during the second shift cycle of a PUSH aborts it without done
    do_cmd(0, 4'h9);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 4'hC;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_shift1_en", sr_en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_sr_rst", sr_rst, 1);
    dn = 0;
    @(negedge clk);
    dn += int'(done);
    chk("abort_depth", depth, 0);
    chk("abort_ready", cmd_ready, 1);
    rst = 1'b0;
    stk.delete(); sticky_m = 1'b0;
    repeat (6) begin @(negedge clk); dn += int'(done); end
    chk("abort_no_done", dn, 0);
    chk("abort_top", sr_top, 0);
    chk("abort_empty", empty, 1);
    chk("abort_err", err, 0);
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      op = r < 4 ? 2'd0 : r < 7 ? 2'd1 : r < 9 ? 2'd2 : 2'd3;
      do_cmd(op, W'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
